// File: rtl/mesh_pkg.sv
// Shared mesh definitions: output port codes, packet field offsets and the routing header type.
// Header fields sit directly below the 8-bit next-jump field, so {trow,tcol,mode} is one contiguous 9-bit slice.
package mesh_pkg;

  localparam logic [1:0] PORT_UP    = 2'd0;
  localparam logic [1:0] PORT_RIGHT = 2'd1;
  localparam logic [1:0] PORT_DOWN  = 2'd2;
  localparam logic [1:0] PORT_LEFT  = 2'd3;
  localparam logic [7:0] PORT_NONE  = 8'hFF;

  typedef struct packed {
    logic [3:0] trow;
    logic [3:0] tcol;
    logic       mode;
  } hdr_t;

  function automatic int nxtjmp_msb(input int sz);
    return sz - 1;
  endfunction

  function automatic int hdr_msb(input int sz);
    return sz - 9;
  endfunction

  function automatic int trow_msb(input int sz);
    return sz - 9;
  endfunction

  function automatic int tcol_msb(input int sz);
    return sz - 13;
  endfunction

  function automatic int mode_pos(input int sz);
    return sz - 17;
  endfunction

endpackage

// File: rtl/route_compute.sv
// Combinational next-hop decision for one router: legality of the terminal, then the output port
// (dimension order chosen by mode, edge exit once the exit router is reached).
module route_compute
  import mesh_pkg::*;
#(
  parameter int id_r    = 0,
  parameter int id_c    = 0,
  parameter int rows    = 4,
  parameter int columns = 4
) (
  input  hdr_t       hdr_i,
  output logic [1:0] port_o,
  output logic       err_o
);

  localparam logic [4:0] R5   = 5'(rows);
  localparam logic [4:0] C5   = 5'(columns);
  localparam logic [4:0] IDR5 = 5'(id_r);
  localparam logic [4:0] IDC5 = 5'(id_c);

  logic [4:0] tr, tc, er, ec;
  logic       row_edge, col_edge, row_in, col_in;

  always_comb begin
    tr       = {1'b0, hdr_i.trow};
    tc       = {1'b0, hdr_i.tcol};
    row_edge = (tr == 5'd0) || (tr == R5 + 5'd1);
    col_edge = (tc == 5'd0) || (tc == C5 + 5'd1);
    row_in   = (tr != 5'd0) && (tr <= R5);
    col_in   = (tc != 5'd0) && (tc <= C5);
    // Corners fail both terms because neither coordinate is then inside the mesh.
    err_o    = !((row_edge && col_in) || (col_edge && row_in));

    er = (tr == 5'd0) ? 5'd1 : ((tr > R5) ? R5 : tr);
    ec = (tc == 5'd0) ? 5'd1 : ((tc > C5) ? C5 : tc);

    port_o = PORT_UP;
    if ((er == IDR5) && (ec == IDC5)) begin
      if (tr == 5'd0)            port_o = PORT_UP;
      else if (tr == R5 + 5'd1)  port_o = PORT_DOWN;
      else if (tc == 5'd0)       port_o = PORT_LEFT;
      else                       port_o = PORT_RIGHT;
    end else if (hdr_i.mode) begin
      if (er != IDR5) port_o = (er < IDR5) ? PORT_UP : PORT_DOWN;
      else            port_o = (ec < IDC5) ? PORT_LEFT : PORT_RIGHT;
    end else begin
      if (ec != IDC5) port_o = (ec < IDC5) ? PORT_LEFT : PORT_RIGHT;
      else            port_o = (er < IDR5) ? PORT_UP : PORT_DOWN;
    end
  end

endmodule

// File: rtl/s_routing_table.sv
// Per-input-port next-hop decoder: rewrites the next-jump field with the local output port (8'hFF if illegal).
// One registered cycle of latency, no stall: every valid input yields an output on the following cycle.
module s_routing_table
  import mesh_pkg::*;
#(
  parameter int pckg_sz = 40,
  parameter int id_r    = 0,
  parameter int id_c    = 0,
  parameter int columns = 4,
  parameter int rows    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  input  logic [pckg_sz-1:0] data_in,
  output logic               out_vld,
  output logic [pckg_sz-1:0] data_out,
  output logic               route_err
);

  localparam int NXT_MSB = nxtjmp_msb(pckg_sz);
  localparam int HDR_MSB = hdr_msb(pckg_sz);
  localparam int HDR_W   = $bits(hdr_t);

  hdr_t               hdr;
  logic [1:0]         port;
  logic               err;
  logic [pckg_sz-1:0] data_d, data_q;
  logic               vld_q, err_q;

  assign hdr = hdr_t'(data_in[HDR_MSB -: HDR_W]);

  route_compute #(
    .id_r    (id_r),
    .id_c    (id_c),
    .rows    (rows),
    .columns (columns)
  ) u_route (
    .hdr_i  (hdr),
    .port_o (port),
    .err_o  (err)
  );

  always_comb begin
    data_d                 = data_in;
    data_d[NXT_MSB -: 8]   = err ? PORT_NONE : {6'b0, port};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_q <= in_vld;
      err_q <= in_vld && err;
      if (in_vld) data_q <= data_d;
    end
  end

  assign data_out  = data_q;
  assign out_vld   = vld_q;
  assign route_err = err_q;

endmodule

// File: tb/tb_s_routing_table.sv
// Drives four routers of a 4x4 mesh from one packet stream and checks every output against a path-level model.
module tb_s_routing_table;

  localparam int R = 4;
  localparam int C = 4;
  localparam int N = 4;
  localparam int IDR [N] = '{2, 3, 4, 1};
  localparam int IDC [N] = '{2, 4, 2, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic [39:0] data_in;
  logic [39:0] dout [N];
  logic        ovld [N];
  logic        rerr [N];

  logic [39:0] exp_data [N];
  logic        exp_vld  [N];
  logic        exp_err  [N];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    s_routing_table #(
      .pckg_sz (40),
      .id_r    (IDR[g]),
      .id_c    (IDC[g]),
      .columns (C),
      .rows    (R)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_vld    (in_vld),
      .data_in   (data_in),
      .out_vld   (ovld[g]),
      .data_out  (dout[g]),
      .route_err (rerr[g])
    );
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Returns the port code a router at (idr,idc) must use, or 255 for an unreachable terminal.
  function automatic int model_port(input int idr, input int idc, input int tr, input int tc, input bit m);
    bit on_top_bot  = (tr == 0 || tr == R + 1) && (tc >= 1 && tc <= C);
    bit on_left_rgt = (tc == 0 || tc == C + 1) && (tr >= 1 && tr <= R);
    int er, ec, dr, dc;
    if (!(on_top_bot || on_left_rgt)) return 255;
    er = (tr < 1) ? 1 : ((tr > R) ? R : tr);
    ec = (tc < 1) ? 1 : ((tc > C) ? C : tc);
    dr = er - idr;
    dc = ec - idc;
    if (dr == 0 && dc == 0) begin
      if (tr == 0)     return 0;
      if (tr == R + 1) return 2;
      if (tc == 0)     return 3;
      return 1;
    end
    if (m ? (dr != 0) : (dc == 0)) return (dr < 0) ? 0 : 2;
    return (dc < 0) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int g = 0; g < N; g++) begin
      chk($sformatf("%s.r%0d%0d.data", tag, IDR[g], IDC[g]), dout[g], exp_data[g]);
      chk($sformatf("%s.r%0d%0d.vld", tag, IDR[g], IDC[g]), {39'b0, ovld[g]}, {39'b0, exp_vld[g]});
      chk($sformatf("%s.r%0d%0d.err", tag, IDR[g], IDC[g]), {39'b0, rerr[g]}, {39'b0, exp_err[g]});
    end
  endtask

  // Presents one input cycle, updates the model, and checks one cycle later.
  task automatic step(input string tag, input bit v, input int tr, input int tc, input bit m,
                      input logic [22:0] pl);
    logic [7:0]  junk;
    logic [3:0]  trn, tcn;
    logic [31:0] rnd;
    int          p;
    rnd  = $urandom;
    junk = rnd[7:0];
    trn  = 4'(tr);
    tcn  = 4'(tc);
    @(negedge clk);
    in_vld  = v;
    data_in = {junk, trn, tcn, m, pl};
    for (int g = 0; g < N; g++) begin
      if (v) begin
        p           = model_port(IDR[g], IDC[g], tr, tc, m);
        exp_data[g] = {(p == 255) ? 8'hFF : 8'(p), trn, tcn, m, pl};
        exp_vld[g]  = 1'b1;
        exp_err[g]  = (p == 255);
      end else begin
        exp_vld[g] = 1'b0;
        exp_err[g] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst     = 1'b0;
    in_vld  = 1'b0;
    data_in = '0;
    for (int g = 0; g < N; g++) begin
      exp_data[g] = '0;
      exp_vld[g]  = 1'b0;
      exp_err[g]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    step("t1", 1'b1, 0, 3, 1'b1, 23'h1234);
    chk("t1.up", {32'b0, dout[0][39:32]}, 40'h00);
    chk("t1.payload", {17'b0, dout[0][22:0]}, 40'h1234);
    step("t2", 1'b1, 0, 3, 1'b0, 23'h1234);
    chk("t2.right", {32'b0, dout[0][39:32]}, 40'h01);
    step("t3a", 1'b1, 3, 5, 1'b1, 23'h1234);
    chk("t3a.right", {32'b0, dout[1][39:32]}, 40'h01);
    step("t3b", 1'b1, 5, 2, 1'b0, 23'h1234);
    chk("t3b.down", {32'b0, dout[2][39:32]}, 40'h02);
    step("t3c", 1'b1, 1, 0, 1'b1, 23'h1234);
    chk("t3c.left", {32'b0, dout[3][39:32]}, 40'h03);
    step("t4a", 1'b1, 0, 0, 1'b1, 23'h1234);
    chk("t4a.ff", {32'b0, dout[0][39:32]}, 40'hFF);
    chk("t4a.err", {39'b0, rerr[0]}, 40'h1);
    step("t4b", 1'b1, 2, 2, 1'b0, 23'h1234);
    chk("t4b.ff", {32'b0, dout[0][39:32]}, 40'hFF);
    step("idle", 1'b0, 0, 0, 1'b0, 23'h0);
    step("t5a", 1'b1, 1, 0, 1'b1, 23'h0abcd);
    chk("t5a.up", {32'b0, dout[0][39:32]}, 40'h00);
    step("t5b", 1'b1, 5, 4, 1'b0, 23'h7f00f);
    chk("t5b.right", {32'b0, dout[0][39:32]}, 40'h01);
    chk("t5b.vld", {39'b0, ovld[0]}, 40'h1);

    // Random targets cover every coordinate 0..15, so out-of-range rows/columns are exercised too.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 23'($urandom));
    end

    // Reset while a packet is being presented: it must be dropped.
    @(negedge clk);
    rst     = 1'b0;
    in_vld  = 1'b1;
    data_in = {8'h00, 4'd0, 4'd2, 1'b1, 23'h55};
    for (int g = 0; g < N; g++) begin
      exp_data[g] = '0;
      exp_vld[g]  = 1'b0;
      exp_err[g]  = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all("t6.rst");
    @(negedge clk);
    rst    = 1'b1;
    in_vld = 1'b0;
    step("t6.resume", 1'b1, 5, 2, 1'b1, 23'h1234);
    chk("t6.resume.down", {32'b0, dout[0][39:32]}, 40'h02);
    step("t6.idle", 1'b0, 0, 0, 1'b0, 23'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
